voice_allocator: RTL and testbench
==================================

# voice_allocator

Assigns incoming MIDI note events to synthesizer voices and drives the note/voice interface of the synth engine: `keys_on`, `note_on`, `cur_key_adr`, `cur_key_val`, `cur_vel_on` and `cur_vel_off`. It sits between the MIDI decoder's event output and the synth engine. It uses the engine's `voice_free` feedback and a least-recently-assigned order to choose free voices, or to steal one when none is free. Every output change is held for a programmable window, so the engine samples it at its once-per-frame slot strobe.

## Interface
- `VOICES`, 8, number of voices.
- `V_WIDTH`, 3, log2(VOICES).
- `HOLD_CYCLES`, 1024, OSC_CLK cycles each committed update is held; must exceed one engine slot frame.
- `OSC_CLK`  in  1  clock.
- `reset_reg_N`  in  1  asynchronous, active-low reset.
- `ev_valid`  in  1  note event present.
- `ev_ready`  out  1  block can accept an event.
- `ev_on`  in  1  1 = note-on, 0 = note-off.
- `ev_key`  in  8  MIDI key number.
- `ev_vel`  in  8  velocity.
- `all_notes_off`  in  1  request to release all voices.
- `voice_free`  in  VOICES  per-voice envelope-idle flags from the engine.
- `keys_on`  out  VOICES  per-voice gate.
- `note_on`  out  1  trigger strobe, held HOLD_CYCLES.
- `cur_key_adr`  out  V_WIDTH  voice targeted by the last commit.
- `cur_key_val`  out  8  key of the last commit.
- `cur_vel_on`  out  8  note-on velocity of the last commit.
- `cur_vel_off`  out  8  note-off velocity of the last commit.
- `stolen`  out  1  last note-on stole a gated voice.

## Operation
- **Reset values**
  - All outputs 0 except `ev_ready` = 1.
  - Per-voice key table = 0.
  - Ages: `age[i] = i`. Ages always form a permutation of 0..VOICES-1; the largest age is the oldest voice.
- **FSM: IDLE -> SCAN -> COMMIT -> HOLD -> IDLE**
  - **IDLE**
    - `ev_ready` = 1.
    - `all_notes_off` has priority over `ev_valid`. It clears all `keys_on` and goes to HOLD. `note_on` stays 0 and ages are unchanged.
    - Otherwise, `ev_valid` latches `ev_on`, `ev_key` and `ev_vel`, then goes to SCAN.
    - A note-on with `ev_vel` = 0 is treated as a note-off with vel_off = 0.
  - **SCAN**
    - Lasts VOICES cycles; voice i is evaluated in scan cycle i, using `voice_free[i]` as sampled in that cycle.
    - Tracks the following candidates:
      - match: a gated voice (`keys_on` = 1) whose key equals `ev_key`; lowest index wins.
      - best free: `keys_on` = 0 and `voice_free` = 1; maximum age wins.
      - best releasing: `keys_on` = 0; maximum age wins.
      - oldest overall: maximum age.
  - **COMMIT** (one cycle)
    - Note-on target, in priority order:
      1. match (retrigger; `keys_on` stays 1)
      2. best free
      3. best releasing
      4. oldest overall (steal; `stolen` = 1)
    - Note-on actions:
      - Set `keys_on[v]`, store the key, update `cur_key_adr`/`cur_key_val`/`cur_vel_on`.
      - Raise `note_on`; `stolen` is 0 unless step 4 was taken.
      - Age update: every voice with `age < age[v]` increments; `age[v]` becomes 0.
    - Note-off with a match:
      - Clear `keys_on[v]`, update `cur_key_adr`/`cur_key_val`/`cur_vel_off`.
      - `note_on` stays 0; ages unchanged.
    - Note-off without a match: the event is consumed, no output changes, and the FSM goes straight to HOLD.
  - **HOLD**
    - Counts HOLD_CYCLES; all outputs stay stable and `ev_ready` = 0.
    - At terminal count: `note_on` = 0, then IDLE.
- `voice_free` changing during SCAN: the per-cycle sample is used; no re-scan.
- Reset asserted in any state returns immediately to the reset values; any in-flight event is lost.

## Timing
- Acceptance edge E0 (`ev_valid` & `ev_ready`); `ev_ready` falls after E0.
- Scan edges E1..E_VOICES.
- Commit edge E(VOICES+1): `keys_on`/`cur_*`/`note_on`/`stolen` change.
- `note_on` falls and `ev_ready` rises at E(VOICES+1+HOLD_CYCLES). The next acceptance is possible at that edge + 1.
- `all_notes_off` accepted at E0: `keys_on` = 0 at E1, `ev_ready` rises at E(1+HOLD_CYCLES).
- `ev_valid` held while `ev_ready` = 0 is not consumed; the event stays pending.
- Widths: age V_WIDTH bits, wrap impossible (permutation). Hold counter is ceil(log2(HOLD_CYCLES+1)) bits.

## Test plan
- **Reset:** check all outputs 0 and `ev_ready` = 1. Then note-on key 60, vel 100 with all `voice_free` = 1 -> voice 7 chosen at E9: `keys_on` = 8'h80, `cur_key_val` = 60, `cur_vel_on` = 100, `note_on` high for exactly 1024 cycles.
- **Second voice / note-off:** a second note-on key 64 -> voice 6, `keys_on` = 8'hC0. Note-off key 60, vel 40 -> `keys_on` = 8'h40, `cur_key_adr` = 7, `cur_vel_off` = 40, `note_on` stays 0.
- **Steal:** eight note-ons, keys 60..67, all gated -> a ninth note-on key 70 steals the voice of key 60 (voice 7). `stolen` = 1 and `keys_on` stays 8'hFF.
- **Velocity 0:** note-on vel 0 for a held key -> behaves as note-off: gate cleared, `cur_vel_off` = 0. Retrigger: note-on for an already held key -> same voice, `note_on` pulse, `keys_on` unchanged.
- **Priority and pending events:**
  - `all_notes_off` and `ev_valid` asserted in the same cycle -> `keys_on` = 0 at E1.
  - The pending event is accepted after the hold completes.
  - Unmatched note-off -> no output change, `ev_ready` returns after HOLD_CYCLES.
- **Mid-operation reset:** assert reset during SCAN and during HOLD -> outputs at reset values immediately. The first note-on afterwards picks voice 7.

Source files
------------

// File: rtl/voice_if.sv
// voice_if: MIDI event handshake plus the note/voice signals toward the synth engine.
interface voice_if #(
  parameter int VOICES = 8,
  parameter int V_WIDTH = 3
);
  logic ev_valid, ev_ready, ev_on, all_notes_off, note_on, stolen;
  logic [7:0] ev_key, ev_vel, cur_key_val, cur_vel_on, cur_vel_off;
  logic [VOICES-1:0] voice_free, keys_on;
  logic [V_WIDTH-1:0] cur_key_adr;
  modport master (
    output ev_valid, ev_on, ev_key, ev_vel, all_notes_off, voice_free,
    input ev_ready, keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, stolen
  );
  modport slave (
    input ev_valid, ev_on, ev_key, ev_vel, all_notes_off, voice_free,
    output ev_ready, keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, stolen
  );
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: assigns MIDI note events to synth voices using free flags and
// least-recently-assigned ages, stealing the oldest voice when all are gated.
module voice_allocator #(
  parameter int VOICES = 8,
  parameter int V_WIDTH = 3,
  parameter int HOLD_CYCLES = 1024
) (
  input logic OSC_CLK,
  input logic reset_reg_N,
  voice_if.slave bus
);
  localparam int C_WIDTH = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, HOLD} state_t;
  state_t state, state_nx;
  logic [V_WIDTH-1:0] age [VOICES];
  logic [7:0] key_tab [VOICES];
  logic [V_WIDTH-1:0] idx, match_v, free_v, rel_v, old_v, tgt;
  logic [7:0] key_l, vel_l;
  logic on_l, anof_l, match_f, free_f, rel_f, gated, hold_done;
  logic [C_WIDTH-1:0] cnt;
  assign gated = bus.keys_on[idx];
  assign hold_done = cnt == C_WIDTH'(HOLD_CYCLES - 1);
  assign tgt = match_f ? match_v : free_f ? free_v : rel_f ? rel_v : old_v;
  assign bus.ev_ready = state == IDLE;
  always_ff @(posedge OSC_CLK or negedge reset_reg_N)
    if (!reset_reg_N) state <= IDLE;
    else state <= state_nx;
  // all_notes_off detours through COMMIT so the gate clear lands one edge after acceptance
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.all_notes_off ? COMMIT : bus.ev_valid ? SCAN : IDLE;
      SCAN: state_nx = idx == V_WIDTH'(VOICES - 1) ? COMMIT : SCAN;
      COMMIT: state_nx = HOLD;
      HOLD: state_nx = hold_done ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge OSC_CLK or negedge reset_reg_N)
    if (!reset_reg_N) begin
      bus.keys_on <= '0;
      bus.note_on <= 1'b0;
      bus.stolen <= 1'b0;
      bus.cur_key_adr <= '0;
      bus.cur_key_val <= '0;
      bus.cur_vel_on <= '0;
      bus.cur_vel_off <= '0;
      for (int i = 0; i < VOICES; i++) begin
        age[i] <= V_WIDTH'(i);
        key_tab[i] <= '0;
      end
      {idx, match_v, free_v, rel_v, old_v} <= '0;
      {key_l, vel_l, on_l, anof_l, match_f, free_f, rel_f} <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.all_notes_off) anof_l <= 1'b1;
          else if (bus.ev_valid) begin
            anof_l <= 1'b0;
            on_l <= bus.ev_on && bus.ev_vel != 8'd0;
            key_l <= bus.ev_key;
            vel_l <= bus.ev_vel;
            idx <= '0;
            {match_f, free_f, rel_f} <= '0;
            old_v <= '0;
          end
        SCAN: begin
          idx <= idx + V_WIDTH'(1);
          if (gated && key_tab[idx] == key_l && !match_f) begin
            match_f <= 1'b1;
            match_v <= idx;
          end
          if (!gated && bus.voice_free[idx] && (!free_f || age[idx] > age[free_v])) begin
            free_f <= 1'b1;
            free_v <= idx;
          end
          if (!gated && (!rel_f || age[idx] > age[rel_v])) begin
            rel_f <= 1'b1;
            rel_v <= idx;
          end
          if (age[idx] > age[old_v]) old_v <= idx;
        end
        COMMIT: begin
          cnt <= '0;
          if (anof_l) bus.keys_on <= '0;
          else if (on_l) begin
            bus.keys_on[tgt] <= 1'b1;
            key_tab[tgt] <= key_l;
            bus.cur_key_adr <= tgt;
            bus.cur_key_val <= key_l;
            bus.cur_vel_on <= vel_l;
            bus.note_on <= 1'b1;
            bus.stolen <= !(match_f || free_f || rel_f);
            for (int i = 0; i < VOICES; i++)
              age[i] <= V_WIDTH'(i) == tgt ? '0 : age[i] < age[tgt] ? age[i] + V_WIDTH'(1) : age[i];
          end else if (match_f) begin
            bus.keys_on[match_v] <= 1'b0;
            bus.cur_key_adr <= match_v;
            bus.cur_key_val <= key_l;
            bus.cur_vel_off <= vel_l;
          end
        end
        HOLD: begin
          cnt <= cnt + C_WIDTH'(1);
          if (hold_done) bus.note_on <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed and randomized checks of voice_allocator against an
// LRU-queue reference model of voice selection.
module tb_voice_allocator;
  localparam int VOICES = 8;
  localparam int V_WIDTH = 3;
  localparam int HOLD = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  voice_if #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) bus ();
  voice_allocator #(.VOICES(VOICES), .V_WIDTH(V_WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .OSC_CLK(clk),
    .reset_reg_N(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [VOICES-1:0] m_gate;
  logic [7:0] m_key [VOICES];
  int m_order [$];  // front = most recently assigned, back = oldest
  logic [V_WIDTH-1:0] m_adr;
  logic [7:0] m_kval, m_von, m_voff;
  logic m_note, m_stolen;
  logic [VOICES-1:0] r_fs;
  logic [36:0] r_snap;
  int r_hold, r_note;
  logic r_stable, r_note_end, r_ready_after;

  function automatic logic [36:0] dut_vec();
    return {bus.keys_on, bus.cur_key_adr, bus.cur_key_val, bus.cur_vel_on, bus.cur_vel_off, bus.note_on, bus.stolen};
  endfunction
  function automatic logic [36:0] mdl_vec();
    return {m_gate, m_adr, m_kval, m_von, m_voff, m_note, m_stolen};
  endfunction
  function automatic void model_reset();
    m_gate = '0;
    for (int i = 0; i < VOICES; i++) m_key[i] = '0;
    m_order = {};
    for (int i = 0; i < VOICES; i++) m_order.push_back(i);
    {m_adr, m_kval, m_von, m_voff, m_note, m_stolen} = '0;
  endfunction
  function automatic int oldest_in(logic [VOICES-1:0] mask);
    for (int k = m_order.size() - 1; k >= 0; k--) if (mask[m_order[k]]) return m_order[k];
    return -1;
  endfunction
  function automatic void model_event(logic on, logic [7:0] key, logic [7:0] vel, logic [VOICES-1:0] fs);
    int v;
    v = -1;
    m_note = 1'b0;
    for (int i = VOICES - 1; i >= 0; i--) if (m_gate[i] && m_key[i] == key) v = i;
    if (on && vel != 8'd0) begin
      m_stolen = 1'b0;
      if (v < 0) v = oldest_in(~m_gate & fs);
      if (v < 0) v = oldest_in(~m_gate);
      if (v < 0) begin
        v = m_order[m_order.size() - 1];
        m_stolen = 1'b1;
      end
      m_gate[v] = 1'b1;
      m_key[v] = key;
      m_adr = V_WIDTH'(v);
      m_kval = key;
      m_von = vel;
      m_note = 1'b1;
      for (int k = 0; k < m_order.size(); k++)
        if (m_order[k] == v) begin
          m_order.delete(k);
          break;
        end
      m_order.push_front(v);
    end else if (v >= 0) begin
      m_gate[v] = 1'b0;
      m_adr = V_WIDTH'(v);
      m_kval = key;
      m_voff = vel;
    end
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    {bus.ev_valid, bus.all_notes_off} = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask
  task automatic run_hold();
    logic [36:0] v;
    r_hold = 0;
    r_note = 0;
    r_stable = 1'b1;
    while (!bus.ev_ready && r_hold < HOLD + 64) begin
      v = dut_vec();
      r_note += int'(bus.note_on);
      if (v[36:2] !== r_snap[36:2] || v[0] !== r_snap[0]) r_stable = 1'b0;
      @(posedge clk);
      #1;
      r_hold++;
    end
    r_note_end = bus.note_on;
  endtask
  task automatic do_event(input logic on, input logic [7:0] key, input logic [7:0] vel, input logic rnd);
    int n;
    n = 0;
    while (!bus.ev_ready && n < 4 * HOLD) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.ev_valid = 1'b1;
    bus.ev_on = on;
    bus.ev_key = key;
    bus.ev_vel = vel;
    @(posedge clk);
    #1;
    bus.ev_valid = 1'b0;
    r_ready_after = bus.ev_ready;
    for (int i = 0; i < VOICES; i++) begin
      if (rnd) bus.voice_free = VOICES'($urandom);
      r_fs[i] = bus.voice_free[i];
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    r_snap = dut_vec();
    run_hold();
    if (n >= 4 * HOLD) r_hold = -1;
  endtask
  task automatic do_anof();
    bus.all_notes_off = 1'b1;
    @(posedge clk);
    #1;
    bus.all_notes_off = 1'b0;
    r_ready_after = bus.ev_ready;
    @(posedge clk);
    #1;
    r_snap = dut_vec();
    run_hold();
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if (dut_vec() !== 37'd0 || bus.ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: outputs %h ready %b, expected 0 and ready 1", dut_vec(), bus.ev_ready);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (dut_vec() !== 37'd0 || bus.ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: outputs %h ready %b, expected 0 and ready 1", dut_vec(), bus.ev_ready);
    end
  endtask
  task automatic test_first_note();
    do_event(1'b1, 8'd60, 8'd100, 1'b0);
    model_event(1'b1, 8'd60, 8'd100, r_fs);
    n_chk++;
    if (r_snap !== mdl_vec() || r_snap[36:29] !== 8'h80 || r_snap[28:26] !== 3'd7) begin
      n_fail++;
      $display("FAIL first_note: got %h expected %h", r_snap, mdl_vec());
    end
    n_chk++;
    if (r_hold !== HOLD || r_note !== HOLD || !r_stable || r_note_end !== 1'b0 || r_ready_after !== 1'b0) begin
      n_fail++;
      $display("FAIL first_note_hold: hold %0d note %0d stable %b end %b rdy %b, expected %0d %0d 1 0 0",
               r_hold, r_note, r_stable, r_note_end, r_ready_after, HOLD, HOLD);
    end
  endtask
  task automatic test_note_off();
    do_event(1'b1, 8'd64, 8'd90, 1'b0);
    model_event(1'b1, 8'd64, 8'd90, r_fs);
    n_chk++;
    if (r_snap !== mdl_vec() || r_snap[36:29] !== 8'hC0) begin
      n_fail++;
      $display("FAIL second_voice: got %h expected %h", r_snap, mdl_vec());
    end
    do_event(1'b0, 8'd60, 8'd40, 1'b0);
    model_event(1'b0, 8'd60, 8'd40, r_fs);
    n_chk++;
    if (r_snap !== mdl_vec() || bus.keys_on !== 8'h40 || bus.cur_key_adr !== 3'd7 || bus.cur_vel_off !== 8'd40) begin
      n_fail++;
      $display("FAIL note_off: got %h expected %h", r_snap, mdl_vec());
    end
    n_chk++;
    if (r_hold !== HOLD || r_note !== 0) begin
      n_fail++;
      $display("FAIL note_off_hold: hold %0d note %0d, expected %0d 0", r_hold, r_note, HOLD);
    end
  endtask
  task automatic test_steal();
    apply_reset();
    bus.voice_free = '1;
    for (int k = 0; k < VOICES; k++) begin
      do_event(1'b1, 8'(60 + k), 8'd80, 1'b0);
      model_event(1'b1, 8'(60 + k), 8'd80, r_fs);
      n_chk++;
      if (r_snap !== mdl_vec()) begin
        n_fail++;
        $display("FAIL fill_%0d: got %h expected %h", k, r_snap, mdl_vec());
      end
    end
    do_event(1'b1, 8'd70, 8'd99, 1'b0);
    model_event(1'b1, 8'd70, 8'd99, r_fs);
    n_chk++;
    if (r_snap !== mdl_vec() || bus.cur_key_adr !== 3'd7 || bus.stolen !== 1'b1 || bus.keys_on !== 8'hFF) begin
      n_fail++;
      $display("FAIL steal: got %h expected %h", r_snap, mdl_vec());
    end
  endtask
  task automatic test_vel0_retrigger();
    do_event(1'b1, 8'd62, 8'd0, 1'b0);
    model_event(1'b1, 8'd62, 8'd0, r_fs);
    n_chk++;
    if (r_snap !== mdl_vec() || bus.keys_on !== 8'hDF || bus.cur_vel_off !== 8'd0 || r_note !== 0) begin
      n_fail++;
      $display("FAIL vel0: got %h note %0d expected %h note 0", r_snap, r_note, mdl_vec());
    end
    do_event(1'b1, 8'd63, 8'd55, 1'b0);
    model_event(1'b1, 8'd63, 8'd55, r_fs);
    n_chk++;
    if (r_snap !== mdl_vec() || bus.keys_on !== 8'hDF || bus.cur_key_adr !== 3'd4 || r_note !== HOLD) begin
      n_fail++;
      $display("FAIL retrigger: got %h note %0d expected %h note %0d", r_snap, r_note, mdl_vec(), HOLD);
    end
  endtask
  task automatic test_priority();
    logic [36:0] prev;
    bus.ev_valid = 1'b1;
    bus.ev_on = 1'b1;
    bus.ev_key = 8'd50;
    bus.ev_vel = 8'd90;
    do_anof();
    m_gate = '0;
    m_note = 1'b0;
    n_chk++;
    if (r_snap !== mdl_vec() || r_snap[36:29] !== 8'h00 || r_ready_after !== 1'b0) begin
      n_fail++;
      $display("FAIL all_notes_off: got %h rdy %b expected %h rdy 0", r_snap, r_ready_after, mdl_vec());
    end
    n_chk++;
    if (r_hold !== HOLD || !r_stable || r_note !== 0) begin
      n_fail++;
      $display("FAIL anof_hold: hold %0d stable %b note %0d, expected %0d 1 0", r_hold, r_stable, r_note, HOLD);
    end
    do_event(1'b1, 8'd50, 8'd90, 1'b0);
    model_event(1'b1, 8'd50, 8'd90, r_fs);
    n_chk++;
    if (r_snap !== mdl_vec() || bus.cur_key_val !== 8'd50) begin
      n_fail++;
      $display("FAIL pending_event: got %h expected %h", r_snap, mdl_vec());
    end
    prev = dut_vec();
    do_event(1'b0, 8'd99, 8'd33, 1'b0);
    model_event(1'b0, 8'd99, 8'd33, r_fs);
    n_chk++;
    if (r_snap !== prev || r_snap !== mdl_vec() || r_hold !== HOLD) begin
      n_fail++;
      $display("FAIL unmatched_off: got %h hold %0d expected %h hold %0d", r_snap, r_hold, prev, HOLD);
    end
  endtask
  task automatic test_random();
    logic on;
    logic [7:0] key, vel;
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      on = $urandom_range(0, 9) < 7;
      key = 8'(60 + $urandom_range(0, 9));
      vel = $urandom_range(0, 7) == 0 ? 8'd0 : 8'($urandom_range(1, 127));
      do_event(on, key, vel, 1'b1);
      model_event(on, key, vel, r_fs);
      n_chk++;
      if (r_snap !== mdl_vec() || r_hold !== HOLD || r_note !== (m_note ? HOLD : 0)) begin
        n_fail++;
        $display("FAIL random_%0d: got %h hold %0d note %0d expected %h", k, r_snap, r_hold, r_note, mdl_vec());
      end
    end
  endtask
  task automatic test_mid_reset();
    bus.voice_free = '1;
    do_event(1'b1, 8'd61, 8'd50, 1'b0);
    bus.ev_valid = 1'b1;
    bus.ev_on = 1'b1;
    bus.ev_key = 8'd62;
    @(posedge clk);
    #1;
    bus.ev_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (dut_vec() !== 37'd0 || bus.ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_scan: outputs %h ready %b, expected 0 and 1", dut_vec(), bus.ev_ready);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    do_event(1'b1, 8'd63, 8'd80, 1'b0);
    model_event(1'b1, 8'd63, 8'd80, r_fs);
    n_chk++;
    if (r_snap !== mdl_vec() || bus.cur_key_adr !== 3'd7) begin
      n_fail++;
      $display("FAIL after_scan_reset: got %h expected %h", r_snap, mdl_vec());
    end
    bus.ev_valid = 1'b1;
    bus.ev_key = 8'd64;
    @(posedge clk);
    #1;
    bus.ev_valid = 1'b0;
    repeat (VOICES + 100) @(posedge clk);
    #1;
    n_chk++;
    if (bus.note_on !== 1'b1 || bus.ev_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_active: note_on %b ready %b, expected 1 0", bus.note_on, bus.ev_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (dut_vec() !== 37'd0 || bus.ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_hold: outputs %h ready %b, expected 0 and 1", dut_vec(), bus.ev_ready);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    do_event(1'b1, 8'd65, 8'd90, 1'b0);
    model_event(1'b1, 8'd65, 8'd90, r_fs);
    n_chk++;
    if (r_snap !== mdl_vec() || bus.cur_key_adr !== 3'd7) begin
      n_fail++;
      $display("FAIL after_hold_reset: got %h expected %h", r_snap, mdl_vec());
    end
  endtask

  initial begin
    {bus.ev_valid, bus.ev_on, bus.all_notes_off} = '0;
    bus.ev_key = '0;
    bus.ev_vel = '0;
    bus.voice_free = '1;
    model_reset();
    test_reset();
    test_first_note();
    test_note_off();
    test_steal();
    test_vel0_retrigger();
    test_priority();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_chk);
    $fatal(1, "time limit");
  end
endmodule
